// File: rtl/alu_result_streamer_if.sv
// Byte-wide valid/ready stream carrying formatted ALU result records.
interface alu_result_streamer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    // Record source side
    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    // Byte consumer side (e.g. the debug UART transmitter)
    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/alu_result_streamer.sv
// Captures ALU results with their opcode/funct fields into a small FIFO and
// streams each entry out as a 6-byte record:
//   {zero,0,opcode} {00,funct} result[31:24] [23:16] [15:8] [7:0]
module alu_result_streamer #(
    parameter int NB_REG     = 32,
    parameter int NB_OPCODE  = 6,
    parameter int NB_FCODE   = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_capture,
    input  logic [NB_OPCODE-1:0]          i_opcode,
    input  logic [NB_FCODE-1:0]           i_funct_code,
    input  logic [NB_REG-1:0]             i_result,
    input  logic                          i_zero,
    alu_result_streamer_if.master         tx,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_overflow
);

    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int NB_ENTRY = 1 + NB_OPCODE + NB_FCODE + NB_REG;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [2:0]       LAST_IDX   = 3'd5;

    logic [NB_ENTRY-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;

    logic [0:0]           state;
    logic [2:0]           idx;
    logic [47:0]          shreg;

    logic                 full;
    logic                 pop;
    logic                 push;
    logic                 handshake;

    logic [NB_ENTRY-1:0]  head;
    logic                 head_zero;
    logic [NB_OPCODE-1:0] head_opcode;
    logic [NB_FCODE-1:0]  head_funct;
    logic [NB_REG-1:0]    head_result;
    logic [47:0]          head_record;

    assign full      = (count == FULL_COUNT);
    assign pop       = (state == ST_IDLE) && (count != '0);
    // A pop in the same cycle frees a slot, so a capture into a full FIFO
    // is still accepted then; the write lands on the slot being read out.
    assign push      = i_capture && (!full || pop);
    assign handshake = tx.tx_valid && tx.tx_ready;

    assign head        = fifo_mem[rd_ptr];
    assign head_zero   = head[NB_ENTRY-1];
    assign head_opcode = head[NB_REG+NB_FCODE +: NB_OPCODE];
    assign head_funct  = head[NB_REG +: NB_FCODE];
    assign head_result = head[NB_REG-1:0];
    assign head_record = {head_zero, 1'b0, head_opcode, 2'b00, head_funct, head_result};

    assign tx.tx_valid  = (state == ST_SEND);
    assign tx.tx_data   = shreg[47:40];
    assign o_busy       = (state == ST_SEND) || (count != '0);
    assign o_fifo_count = count;

    // Record storage: entries are written at the write pointer on each accepted capture
    always_ff @(posedge i_clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {i_zero, i_opcode, i_funct_code, i_result};
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            if (i_capture && !push) begin
                o_overflow <= 1'b1;
            end
        end
    end

    // Send FSM: load the head record, then shift one byte out per handshake
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= ST_IDLE;
            idx   <= '0;
            shreg <= '0;
        end else if (pop) begin
            shreg <= head_record;
            idx   <= '0;
            state <= ST_SEND;
        end else if ((state == ST_SEND) && handshake) begin
            shreg <= {shreg[39:0], 8'h00};
            idx   <= idx + 3'd1;
            if (idx == LAST_IDX) begin
                state <= ST_IDLE;
            end
        end
    end

endmodule

// File: doc/alu_result_streamer.md
# alu_result_streamer

Captures ALU results together with the instruction fields that produced them and streams them out as fixed 6-byte records over a byte-wide valid/ready interface. It sits on the EX stage result path, after `alu` and `alu_control`, and feeds the debug unit's UART transmitter. This lets a host read back what the ALU computed for each opcode/function code.

## Interface
- `NB_REG`, 32, ALU result width; the record format is fixed for 32.
- `NB_OPCODE`, 6, instruction opcode width.
- `NB_FCODE`, 6, function code width.
- `FIFO_DEPTH`, 4, record FIFO entries; must be a power of 2, at least 2.
- `i_clock`  in  1  single clock; all state changes on its rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_capture`  in  1  strobe that samples the four fields below into the FIFO this cycle.
- `i_opcode`  in  6  instruction opcode that drove `alu_control`.
- `i_funct_code`  in  6  function code that drove `alu_control`.
- `i_result`  in  32  ALU `o_result`.
- `i_zero`  in  1  ALU `o_zero`.
- `o_tx_data`  out  8  current record byte.
- `o_tx_valid`  out  1  `o_tx_data` is valid.
- `i_tx_ready`  in  1  consumer accepts the byte when both `o_tx_valid` and `i_tx_ready` are high.
- `o_busy`  out  1  a record is being sent or the FIFO is non-empty.
- `o_fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of stored records.
- `o_overflow`  out  1  sticky: at least one capture was dropped.

## Operation
- Record layout, sent in this byte order:
  - byte0 = {zero, 1'b0, opcode[5:0]}
  - byte1 = {2'b00, funct[5:0]}
  - bytes 2..5 = result[31:24], [23:16], [15:8], [7:0] (MSB first)
- The FIFO stores 45-bit entries {zero, opcode, funct, result}. It is a circular buffer; read and write pointers wrap modulo `FIFO_DEPTH`.
- Capture: if `i_capture` is high and the FIFO is not full, the entry is written at the write pointer.
- Capture when full: the entry is dropped and `o_overflow` is set to 1. It clears only on reset.
- Capture when full in the same cycle as a pop: the pop frees a slot, so the capture is accepted and the count is unchanged.
- The FSM has two states: IDLE and SEND. It uses a 3-bit byte index `idx` and a 48-bit shift register.
  - IDLE with the FIFO non-empty: pop the head into the shift register (formatted as above), set `idx` = 0, go to SEND.
  - IDLE with the FIFO empty: stay in IDLE.
  - SEND: `o_tx_valid` = 1 and `o_tx_data` = shift register [47:40].
  - On a handshake: shift left by 8 and increment `idx`.
  - On the handshake at `idx` = 5: go to IDLE. The next record starts one cycle later at the earliest.
- While `o_tx_valid` is high and `i_tx_ready` is low, `o_tx_data` is held stable. `o_tx_valid` never drops without a handshake.
- `o_busy` = (state == SEND) | (count != 0).
- Capture is independent of the FSM: captures keep arriving while a record is being sent.

## Timing
- Reset values:
  - `o_tx_valid` = 0, `o_tx_data` = 8'h00
  - `o_busy` = 0, `o_fifo_count` = 0, `o_overflow` = 0
  - state = IDLE, pointers = 0
- Reset takes priority over capture and handshake in the same cycle. Reset in the middle of a record discards the partial record and all FIFO contents; no bytes are sent after reset deasserts until a new capture.
- Latency with an empty FIFO and IDLE state:
  - capture sampled at edge k
  - `o_fifo_count` = 1 after edge k
  - pop at edge k+1; `o_tx_valid` = 1 with byte0 after edge k+1
  - `o_fifo_count` returns to 0 after edge k+1
- Throughput with `i_tx_ready` held high: 6 cycles per record plus 1 IDLE cycle, i.e. 7 cycles per record.
- `o_fifo_count` updates on the same edge as the push or pop. A simultaneous push and pop leaves it unchanged.

## Test plan
- a=2, b=1, opcode 0x00, funct 0x20 (ADD), capture one record with ready high → bytes 00 20 00 00 00 03; `o_tx_valid` first high 1 cycle after the capture edge; `o_busy` falls after byte 5.
- a=2, b=2, SUB (funct 0x22), result 0, zero=1 → bytes 80 22 00 00 00 00.
- Opcode 0x0f (LUI) with result 0x00010000 → bytes 0F 00 00 01 00 00. Hold `i_tx_ready` low for 5 cycles during byte 2 → `o_tx_data` stays 0x00 and `o_tx_valid` stays high throughout; the sequence resumes intact.
- `i_tx_ready` low, 6 back-to-back captures (results 1..6, `FIFO_DEPTH`=4) → the first capture is popped into the shift register, leaving 4 in the FIFO; the 6th is dropped and `o_overflow`=1. Release ready → results 1..5 stream in order with `o_fifo_count` decrementing, and `o_overflow` stays 1.
- FIFO full with a capture coinciding with the IDLE pop → count stays at 4, the capture is accepted, and `o_overflow` stays 0.
- Assert `i_reset` for one cycle after byte 3 of a record with 2 records queued → all outputs return to reset values next cycle and no further bytes appear.
